// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with HI/LO registers.
//
// Accepts mult/multu/div/divu/mthi/mtlo from the E stage. Arithmetic ops
// capture their operands, hold busy for a fixed number of cycles and then
// write HI/LO with a one-cycle done pulse. mthi/mtlo write immediately.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   start      issue strobe, one cycle per instruction
//   md_op      000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   rs_val     first operand (dividend / multiplicand / mthi-mtlo source)
//   rt_val     second operand (divisor / multiplier)
//   busy       high while an arithmetic op is in flight
//   stall_req  combinational stall request to the hazard unit
//   done       one-cycle pulse after HI/LO are written by an arithmetic op
//   hi, lo     HI and LO registers
//
// state | meaning
// IDLE  | ready to accept a command; mthi/mtlo complete here
// BUSY  | arithmetic op in flight, cnt counts remaining cycles down to 1

module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
    localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        done_nx;
    logic [31:0] hi_nx, lo_nx;
    logic        load;

    // Captured operands. Only md_op[1:0] is kept: a captured op is always
    // arithmetic, so bit 2 is known to be zero.
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;

    logic        accept;
    logic        is_arith;

    logic [63:0] ext_a, ext_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b, quo_m, rem_m, quo, rem;

    assign is_arith  = ~md_op[2];
    // 110/111 are reserved and never accepted.
    assign accept    = start && (state == IDLE) && !(md_op[2] && md_op[1]);
    assign busy      = (state == BUSY);
    assign stall_req = busy || (start && is_arith);

    // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the
    // product are correct for both signed and unsigned operands.
    always_comb begin
        ext_a = op_q[0] ? {32'h0, a_q} : {{32{a_q[31]}}, a_q};
        ext_b = op_q[0] ? {32'h0, b_q} : {{32{b_q[31]}}, b_q};
        prod  = ext_a * ext_b;
    end

    // Divide on magnitudes with one unsigned divider, then fix signs:
    // quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    // A zero divisor is replaced by 1 only to keep the divider defined;
    // its result is never written.
    always_comb begin
        a_neg = ~op_q[0] & a_q[31];
        b_neg = ~op_q[0] & b_q[31];
        mag_a = a_neg ? -a_q : a_q;
        mag_b = b_neg ? -b_q : b_q;
        if (b_q == 32'h0) begin
            mag_b = 32'h1;
        end
        quo_m = mag_a / mag_b;
        rem_m = mag_a % mag_b;
        quo   = (a_neg ^ b_neg) ? -quo_m : quo_m;
        rem   = a_neg ? -rem_m : rem_m;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        hi_nx    = hi;
        lo_nx    = lo;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_arith) begin
                        state_nx = BUSY;
                        load     = 1'b1;
                        cnt_nx   = md_op[1] ? DIV_N : MULT_N;
                    end else if (md_op[0]) begin
                        lo_nx = rs_val;
                    end else begin
                        hi_nx = rs_val;
                    end
                end
            end
            BUSY: begin
                cnt_nx = cnt - 4'd1;
                // <= 1 also retires a (never loaded) zero count safely.
                if (cnt <= 4'd1) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                    done_nx  = 1'b1;
                    if (!op_q[1]) begin
                        hi_nx = prod[63:32];
                        lo_nx = prod[31:0];
                    end else if (b_q != 32'h0) begin
                        hi_nx = rem;
                        lo_nx = quo;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            done  <= 1'b0;
            hi    <= 32'h0;
            lo    <= 32'h0;
            a_q   <= 32'h0;
            b_q   <= 32'h0;
            op_q  <= 2'b00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            done  <= done_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
            if (load) begin
                a_q  <= rs_val;
                b_q  <= rt_val;
                op_q <= md_op[1:0];
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl with default parameters
// (mult 5 cycles, div 10 cycles). Inputs change and outputs are sampled
// around the falling edge.

module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          n;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[16];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = rs;
        rt_val = rt;
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        issue(v.op, v.rs, v.rt);
        chk("stall_req_at_issue", {31'h0, stall_req}, (v.op < 3'd4) ? 32'h1 : 32'h0);
        @(negedge clk);
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        if (v.op >= 3'd4) begin
            chk("move_busy", {31'h0, busy}, 32'h0);
            chk("move_done", {31'h0, done}, 32'h0);
            chk("move_hi", hi, v.ehi);
            chk("move_lo", lo, v.elo);
        end else begin
            cyc = 0;
            while (busy === 1'b1 && cyc < 20) begin
                chk("done_low_in_busy", {31'h0, done}, 32'h0);
                chk("hi_held_in_busy", hi, m_hi);
                chk("lo_held_in_busy", lo, m_lo);
                chk("stall_in_busy", {31'h0, stall_req}, 32'h1);
                cyc++;
                @(negedge clk);
            end
            chk("busy_cycles", 32'(cyc), 32'(v.n));
            chk("done_pulse", {31'h0, done}, 32'h1);
            chk("result_hi", hi, v.ehi);
            chk("result_lo", lo, v.elo);
            @(negedge clk);
            chk("done_one_cycle", {31'h0, done}, 32'h0);
        end
        m_hi = v.ehi;
        m_lo = v.elo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        int cyc;

        vecs[0]  = '{3'b100, 32'hABCD0000, 32'h00000000, 0,  32'hABCD0000, 32'h00000000};
        vecs[1]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
        vecs[3]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{3'b011, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
        vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[6]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{3'b011, 32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF};
        vecs[8]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[9]  = '{3'b000, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
        vecs[10] = '{3'b100, 32'h00000011, 32'h00000000, 0,  32'h00000011, 32'h00000000};
        vecs[11] = '{3'b101, 32'h00000022, 32'h00000000, 0,  32'h00000011, 32'h00000022};
        vecs[12] = '{3'b011, 32'h00000005, 32'h00000000, 10, 32'h00000011, 32'h00000022};
        vecs[13] = '{3'b000, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};
        vecs[14] = '{3'b101, 32'h00005A5A, 32'h00000000, 0,  32'h00000001, 32'h00005A5A};
        vecs[15] = '{3'b010, 32'hFFFFFFF9, 32'h00000000, 10, 32'h00000001, 32'h00005A5A};

        // Reset with a mult start presented: reset wins.
        reset  = 1'b1;
        start  = 1'b1;
        md_op  = 3'b000;
        rs_val = 32'h3;
        rt_val = 32'h3;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", {31'h0, busy}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i]);
        end

        // mthi issued during BUSY is ignored.
        issue(3'b000, 32'h3, 32'h4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        md_op  = 3'b100;
        rs_val = 32'hABCD0000;
        #1;
        chk("stall_mthi_busy", {31'h0, stall_req}, 32'h1);
        @(negedge clk);
        start = 1'b0;
        chk("hi_held_mthi_busy", hi, m_hi);
        cyc = 0;
        while (busy === 1'b1 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        chk("mthi_busy_done", {31'h0, done}, 32'h1);
        chk("mthi_busy_hi", hi, 32'h0);
        chk("mthi_busy_lo", lo, 32'h0000000C);
        m_hi = 32'h0;
        m_lo = 32'h0000000C;

        // Start presented in the last busy cycle is dropped.
        issue(3'b000, 32'h5, 32'h6);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("last_cycle_busy", {31'h0, busy}, 32'h1);
        start  = 1'b1;
        md_op  = 3'b001;
        rs_val = 32'h7;
        rt_val = 32'h9;
        @(negedge clk);
        start = 1'b0;
        chk("last_cycle_end_busy", {31'h0, busy}, 32'h0);
        chk("last_cycle_done", {31'h0, done}, 32'h1);
        chk("last_cycle_lo", lo, 32'h0000001E);
        @(negedge clk);
        chk("late_start_ignored", {31'h0, busy}, 32'h0);
        chk("late_start_no_done", {31'h0, done}, 32'h0);
        chk("late_start_lo", lo, 32'h0000001E);
        m_lo = 32'h0000001E;

        // Reserved opcodes are ignored.
        for (int k = 6; k < 8; k++) begin
            issue(3'(k), 32'h12345678, 32'h1);
            chk("reserved_stall", {31'h0, stall_req}, 32'h0);
            @(negedge clk);
            start = 1'b0;
            chk("reserved_busy", {31'h0, busy}, 32'h0);
            chk("reserved_hi", hi, m_hi);
            chk("reserved_lo", lo, m_lo);
        end

        // Reset on the 3rd busy cycle abandons the mult.
        issue(3'b000, 32'hFFFFFFFF, 32'h2);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_busy", {31'h0, busy}, 32'h0);
        chk("midreset_done", {31'h0, done}, 32'h0);
        chk("midreset_hi", hi, 32'h0);
        chk("midreset_lo", lo, 32'h0);
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        chk("midreset_no_late_done", {31'h0, saw_done}, 32'h0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        run_vec('{3'b000, 32'h00000005, 32'h00000007, 5, 32'h00000000, 32'h00000023});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
